// File: rtl/alu_share_arb.sv
// Two-requester arbiter in front of one shared, registered ALU with a valid/ready result port.
// Define ALU_ARB_FAIR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_share_arb #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [2:0]       op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [2:0]       op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt1,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             res_valid,
    output logic             res_id,
    input  logic             res_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       op_p0;
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic             id_p0;
    logic             pick1;
    logic [WIDTH-1:0] alu_res;

    function automatic logic [WIDTH-1:0] alu(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic        [WIDTH-1:0] r;
        sa = a;
        sb = b;
        r  = '0;
        case (op)
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b010:  r = a + b;
            3'b011:  r = a >> b[4:0];
            3'b100:  r = a ^ b;
            3'b101:  r = ~(a | b);
            3'b110:  r = a - b;
            3'b111:  r = {{(WIDTH-1){1'b0}}, (sa < sb)};
            default: r = '0;
        endcase
        return r;
    endfunction

`ifdef ALU_ARB_FAIR_EN
    // last = id of the requester served most recently; a tie goes to the other one.
    logic last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (gnt0 || gnt1) begin
            last <= gnt1;
        end
    end

    always_comb begin
        pick1 = req1 && (!req0 || !last);
    end
`else
    always_comb begin
        pick1 = req1 && !req0;
    end
`endif

    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        case (state)
            IDLE: begin
                if (rst_n && (req0 || req1)) begin
                    gnt0      = !pick1;
                    gnt1      = pick1;
                    state_nxt = EXEC;
                end
            end
            EXEC:    state_nxt = RESP;
            RESP: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stage p0: winner's operands captured at the grant edge.
    always_ff @(posedge clk) begin
        if (gnt0 || gnt1) begin
            op_p0 <= gnt1 ? op1 : op0;
            a_p0  <= gnt1 ? a1  : a0;
            b_p0  <= gnt1 ? b1  : b0;
            id_p0 <= gnt1;
        end
    end

    always_comb begin
        alu_res = alu(op_p0, a_p0, b_p0);
    end

    // Stage p1: registered result, held through RESP and kept after consumption.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res       <= '0;
            zero      <= 1'b0;
            res_id    <= 1'b0;
            res_valid <= 1'b0;
        end else if (state == EXEC) begin
            res       <= alu_res;
            zero      <= (alu_res == '0);
            res_id    <= id_p0;
            res_valid <= 1'b1;
        end else if (state == RESP && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Shared-ALU arbiter and sequencer for the Org_Lab datapath. Two requesters (e.g. the address-generation path and the execute path) share one 32-bit ALU built from the same primitives as `and32`, `or32` and `add32`. The block arbitrates between them, latches the winner's operands, computes one operation and holds the registered result under a valid/ready handshake until it is consumed.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `req0` in 1: requester 0 operation request.
- `op0` in 3: requester 0 ALU opcode.
- `a0`, `b0` in WIDTH: requester 0 operands.
- `gnt0` out 1: accept strobe for requester 0; operands are sampled at this edge.
- `req1`, `op1`, `a1`, `b1`, `gnt1`: same as above, for requester 1.
- `res` out WIDTH: registered result.
- `zero` out 1: registered, equals (`res` == 0).
- `res_valid` out 1: the result is valid.
- `res_id` out 1: index of the requester that owns `res`.
- `res_ready` in 1: consumer accepts the result.

## Operation
- FSM states:
  - IDLE: no operation in progress.
  - EXEC: compute from the latched operands and register the result.
  - RESP: hold the result until it is consumed.
- IDLE:
  - If any `req` is high, assert exactly one `gnt` combinationally.
  - At that edge, latch op/a/b and the requester id, then move to EXEC.
  - With no request, stay in IDLE.
- EXEC: register `res`, `zero` and `res_id`, set `res_valid`, then move to RESP.
- RESP:
  - Hold `res`, `zero`, `res_id` and `res_valid` stable.
  - When `res_ready` is high, clear `res_valid` at that edge and move to IDLE.
- Grants are asserted only in IDLE, and `gnt0`/`gnt1` are never high together.
- Requesters hold `req` and operands stable until their grant. Deasserting `req` before the grant is legal; no grant is issued.
- Opcodes:
  - 000 AND, 001 OR, 010 ADD, 011 SRL (shift `a` right logically by `b[4:0]`).
  - 100 XOR, 101 NOR, 110 SUB (`a`-`b`), 111 SLT (signed; result 1 or 0, zero-extended).
- Arithmetic: ADD and SUB wrap modulo 2^WIDTH; carry and overflow are dropped.
- Arbitration is round-robin or fixed priority depending on configuration (see Configuration).
- `res` keeps its last value after consumption; only `res_valid` clears.

## Timing
- Reset values:
  - `res`=0, `zero`=0, `res_valid`=0, `res_id`=0, state=IDLE, round-robin pointer "last served"=1.
  - `gnt0`/`gnt1` are forced to 0 while `rst_n`=0.
- Latency: grant in cycle N, `res_valid` high from cycle N+2.
- Minimum 3 cycles per operation when `res_ready` is tied high, so the next grant can occur in cycle N+3.
- Backpressure: RESP lasts indefinitely while `res_ready`=0, and no grant is issued meanwhile.
- `res_ready` is ignored outside RESP.
- Reset mid-operation (EXEC or RESP): at that edge the state returns to IDLE, `res_valid` clears, the in-flight result is discarded and the pointer resets.

## Configuration
- `ALU_ARB_FAIR_EN` defined: round-robin arbitration.
  - When both requesters are high, grant the one not served last.
  - The pointer updates on every grant.
  - After reset, requester 0 wins the first tie.
- `ALU_ARB_FAIR_EN` undefined: fixed priority, requester 0 always wins ties. The pointer is not implemented.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `req0`=1 → `gnt0`=0, `res_valid`=0, `res`=0. After release, `gnt0` pulses in the first IDLE cycle.
- Single AND: `req0`, `op0`=000, `a0`=7, `b0`=5 → `gnt0` in cycle 0; in cycle 2 `res_valid`=1, `res`=5, `res_id`=0, `zero`=0.
- Tie with `ALU_ARB_FAIR_EN`: both requesters held high with `res_ready`=1.
  - Port 0: ADD 0xFFFFFFFF+1. Port 1: SUB 3-3.
  - Required grant order: 0, 1, 0.
  - Each result is `res`=0 with `zero`=1.
  - Without the macro, the grant order is 0, 0, 0.
- Backpressure: `res_ready`=0 for 5 cycles in RESP while `req1` is high → `res`/`res_valid` stable and `gnt1`=0. After `res_ready`=1, `gnt1` pulses on the following cycle.
- Opcode edges:
  - SLT 0xFFFFFFFF vs 1 → 1.
  - SRL 0x80000000 by 31 → 1.
  - NOR 0 vs 0 → 0xFFFFFFFF.
  - OR 0xF0 vs 0x0F → 0xFF.
- Reset in RESP: pull `rst_n` low for one cycle → `res_valid`=0 next cycle and the result is lost. A later tie grants requester 0.
